// File: rtl/serial_tx_frame_if.sv
// Parallel-load / start / done handshake and serial line between the
// read controller and the serial frame transmitter.
interface serial_tx_frame_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] DATA_IN;
    logic                  PARALLEL_LOAD;
    logic                  Tx_DATA;
    logic                  TX_OUT;
    logic                  Tx_DONE;
    logic [2:0]            DEBUG_STATE;

    // Controller side: supplies the word and the load/start strobes
    modport master (
        output DATA_IN, PARALLEL_LOAD, Tx_DATA,
        input  TX_OUT, Tx_DONE, DEBUG_STATE
    );

    // Transmitter side
    modport slave (
        input  DATA_IN, PARALLEL_LOAD, Tx_DATA,
        output TX_OUT, Tx_DONE, DEBUG_STATE
    );
endinterface

// File: rtl/serial_tx_frame.sv
// UART-style serial frame transmitter: start bit, DATA_WIDTH data bits
// LSB first, optional parity bit, one stop bit. Each bit lasts BAUD_DIV
// clocks. TX_OUT and Tx_DONE come straight from flops.
module serial_tx_frame #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BAUD_DIV   = 4,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    serial_tx_frame_if.slave  bus
);
    localparam int unsigned BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [BIT_W-1:0]      r_bit;
    logic [BAUD_W-1:0]     r_baud;
    logic                  r_parity;
    logic                  r_tx_out;
    logic                  r_done;

    logic                  w_baud_end;
    logic [DATA_WIDTH-1:0] w_word;
    logic [DATA_WIDTH-1:0] w_shift_nxt;

    // Bit-time boundary, word that a start in this cycle will send, next shift value
    assign w_baud_end  = (r_baud == BAUD_W'(BAUD_DIV - 1));
    assign w_word      = bus.PARALLEL_LOAD ? bus.DATA_IN : r_shift;
    assign w_shift_nxt = r_shift >> 1;

    assign bus.TX_OUT      = r_tx_out;
    assign bus.Tx_DONE     = r_done;
    assign bus.DEBUG_STATE = r_state;

    // Frame sequencer; the line level for the next bit is registered on the
    // edge that enters it, so there is no input-to-output combinational path
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_bit    <= '0;
            r_baud   <= '0;
            r_parity <= 1'b0;
            r_tx_out <= 1'b1;
            r_done   <= 1'b1;
        end else begin
            if (r_state != IDLE) begin
                r_baud <= w_baud_end ? '0 : r_baud + BAUD_W'(1);
            end
            case (r_state)
                IDLE: begin
                    r_tx_out <= 1'b1;
                    r_done   <= 1'b1;
                    if (bus.PARALLEL_LOAD) begin
                        r_shift <= bus.DATA_IN;
                    end
                    if (bus.Tx_DATA) begin
                        // Parity is frozen here from the word actually sent
                        r_parity <= (^w_word) ^ 1'(PARITY_ODD);
                        r_state  <= START;
                        r_baud   <= '0;
                        r_bit    <= '0;
                        r_tx_out <= 1'b0;
                        r_done   <= 1'b0;
                    end
                end
                START: begin
                    if (w_baud_end) begin
                        r_state  <= DATA;
                        r_tx_out <= r_shift[0];
                    end
                end
                DATA: begin
                    if (w_baud_end) begin
                        r_shift <= w_shift_nxt;
                        if (r_bit == BIT_W'(DATA_WIDTH - 1)) begin
                            r_bit <= '0;
                            if (PARITY_EN != 0) begin
                                r_state  <= PARITY;
                                r_tx_out <= r_parity;
                            end else begin
                                r_state  <= STOP;
                                r_tx_out <= 1'b1;
                            end
                        end else begin
                            r_bit    <= r_bit + BIT_W'(1);
                            r_tx_out <= w_shift_nxt[0];
                        end
                    end
                end
                PARITY: begin
                    if (w_baud_end) begin
                        r_state  <= STOP;
                        r_tx_out <= 1'b1;
                    end
                end
                STOP: begin
                    if (w_baud_end) begin
                        r_state  <= IDLE;
                        r_tx_out <= 1'b1;
                        r_done   <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_tx_out <= 1'b1;
                    r_done   <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_tx_frame.sv
// Bench for serial_tx_frame: one instance with defaults (no parity), one with
// even parity. A negedge monitor captures every frame and checks it against a
// queue of expected frames pushed by the stimulus.
module tb_serial_tx_frame;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    serial_tx_frame_if #(.DATA_WIDTH(8)) if0 ();
    serial_tx_frame_if #(.DATA_WIDTH(8)) if1 ();

    serial_tx_frame #(.DATA_WIDTH(8), .BAUD_DIV(4), .PARITY_EN(0), .PARITY_ODD(0))
        u_dut0 (.CLK(clk), .RESET(rst), .bus(if0));
    serial_tx_frame #(.DATA_WIDTH(8), .BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(0))
        u_dut1 (.CLK(clk), .RESET(rst), .bus(if1));

    typedef struct packed {
        logic [7:0] data;
        logic       has_par;
        logic       par;
        logic [7:0] len;
    } exp_t;

    typedef struct {
        int         sel;
        logic [7:0] data;
        int         mode;   // 0 load+start same cycle, 1 load then start
        logic [7:0] len;
        logic       par;
    } vec_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    int n_tests = 0;
    int n_fail  = 0;

    bit          cap_on [2] = '{1'b0, 1'b0};
    int          cap_n  [2] = '{0, 0};
    logic [63:0] cap_v  [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic drive(input int s, input logic [7:0] d, input logic ld, input logic tx);
        if (s == 0) begin
            if0.DATA_IN = d; if0.PARALLEL_LOAD = ld; if0.Tx_DATA = tx;
        end else begin
            if1.DATA_IN = d; if1.PARALLEL_LOAD = ld; if1.Tx_DATA = tx;
        end
    endtask

    function automatic logic [4:0] outs(input int s);
        if (s == 0) return {if0.TX_OUT, if0.Tx_DONE, if0.DEBUG_STATE};
        return {if1.TX_OUT, if1.Tx_DONE, if1.DEBUG_STATE};
    endfunction

    function automatic logic get_done(input int s);
        return (s == 0) ? if0.Tx_DONE : if1.Tx_DONE;
    endfunction

    function automatic logic get_tx(input int s);
        return (s == 0) ? if0.TX_OUT : if1.TX_OUT;
    endfunction

    function automatic logic exp_bit(input exp_t e, input int k);
        int b;
        b = k / 4;
        if (b == 0) return 1'b0;
        if (b <= 8) return e.data[b-1];
        if (b == 9 && e.has_par) return e.par;
        return 1'b1;
    endfunction

    task automatic push_exp(input int s, input exp_t e);
        if (s == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    // Compare a completed captured frame with the oldest expected frame
    task automatic check_frame(input int s);
        exp_t e;
        int   mism;
        if ((s == 0 && exp_q0.size() == 0) || (s == 1 && exp_q1.size() == 0)) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_frame dut%0d: got a frame of %0d cycles, required none", s, cap_n[s]);
            return;
        end
        e = (s == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check($sformatf("dut%0d_len_%02h", s, e.data), 32'(cap_n[s]), 32'(e.len));
        mism = 0;
        for (int k = 0; k < int'(e.len) && k < cap_n[s] && k < 64; k++) begin
            if (cap_v[s][k] !== exp_bit(e, k)) mism++;
        end
        check($sformatf("dut%0d_bits_%02h_mismatches", s, e.data), 32'(mism), 32'd0);
    endtask

    // Frame monitor: a frame is every consecutive cycle with Tx_DONE low
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (rst) begin
                cap_on[s] = 1'b0;
            end else if (!get_done(s)) begin
                if (!cap_on[s]) begin
                    cap_on[s] = 1'b1;
                    cap_n[s]  = 0;
                    cap_v[s]  = '0;
                end
                if (cap_n[s] < 64) cap_v[s][cap_n[s]] = get_tx(s);
                cap_n[s]++;
            end else if (cap_on[s]) begin
                cap_on[s] = 1'b0;
                check_frame(s);
            end
        end
    end

    // Launch a frame; mode 2 starts without loading (sends current register)
    task automatic start_frame(input int s, input logic [7:0] d, input int mode,
                               input logic [7:0] len, input logic par, input bit push);
        exp_t e;
        @(posedge clk); #1;
        if (mode == 0)      drive(s, d, 1'b1, 1'b1);
        else if (mode == 1) drive(s, d, 1'b1, 1'b0);
        else                drive(s, 8'hC3, 1'b0, 1'b1);
        if (mode == 1) begin
            @(posedge clk); #1;
            drive(s, ~d, 1'b0, 1'b1);
        end
        e.data = d; e.has_par = (s == 1); e.par = par; e.len = len;
        if (push) push_exp(s, e);
        @(posedge clk); #1;
        drive(s, 8'($urandom), 1'b0, 1'b0);
        @(negedge clk);
        check($sformatf("dut%0d_start_latency_%02h", s, d), 32'(outs(s)), 32'({1'b0, 1'b0, 3'd1}));
    endtask

    task automatic wait_idle(input int s);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (get_done(s)) ok = 1'b1;
        end
        check($sformatf("dut%0d_idle_reached", s), 32'(ok), 32'd1);
    endtask

    vec_t vecs [8];

    initial begin
        int stay;
        bit seen;

        vecs[0] = '{0, 8'hA5, 0, 8'd40, 1'b0};
        vecs[1] = '{0, 8'h3C, 1, 8'd40, 1'b0};
        vecs[2] = '{0, 8'hFF, 0, 8'd40, 1'b0};
        vecs[3] = '{0, 8'h00, 1, 8'd40, 1'b0};
        vecs[4] = '{1, 8'hA5, 1, 8'd44, 1'b0};
        vecs[5] = '{1, 8'h07, 1, 8'd44, 1'b1};
        vecs[6] = '{1, 8'h01, 0, 8'd44, 1'b1};
        vecs[7] = '{1, 8'hFF, 1, 8'd44, 1'b0};

        drive(0, 8'h00, 1'b0, 1'b0);
        drive(1, 8'h00, 1'b0, 1'b0);

        // Reset for 3 cycles, then idle outputs for 10 cycles
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("reset_idle_dut0_c%0d", i), 32'(outs(0)), 32'({1'b1, 1'b1, 3'd0}));
            check($sformatf("reset_idle_dut1_c%0d", i), 32'(outs(1)), 32'({1'b1, 1'b1, 3'd0}));
        end

        // Table-driven frames
        for (int v = 0; v < 8; v++) begin
            start_frame(vecs[v].sel, vecs[v].data, vecs[v].mode, vecs[v].len, vecs[v].par, 1'b1);
            wait_idle(vecs[v].sel);
        end

        // Load/start pulses while busy are ignored; no restart afterwards
        start_frame(0, 8'h3C, 0, 8'd40, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        #1 drive(0, 8'hFF, 1'b1, 1'b1);
        @(posedge clk);
        #1 drive(0, 8'h00, 1'b0, 1'b0);
        wait_idle(0);
        stay = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (get_done(0)) stay++;
        end
        check("busy_no_restart", 32'(stay), 32'd6);

        // Reset during the 4th data bit aborts the frame
        start_frame(0, 8'h55, 0, 8'd40, 1'b0, 1'b0);
        repeat (17) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_next_edge_idle", 32'(outs(0)), 32'({1'b1, 1'b1, 3'd0}));

        // Start without load after reset sends the cleared register
        start_frame(0, 8'h00, 2, 8'd40, 1'b0, 1'b1);
        wait_idle(0);
        start_frame(0, 8'h5A, 0, 8'd40, 1'b0, 1'b1);
        wait_idle(0);

        // Back-to-back: second start on the first Tx_DONE=1 cycle
        start_frame(0, 8'h01, 0, 8'd40, 1'b0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (get_done(0)) seen = 1'b1;
        end
        check("b2b_first_done", 32'(seen), 32'd1);
        drive(0, 8'h80, 1'b1, 1'b1);
        push_exp(0, '{data: 8'h80, has_par: 1'b0, par: 1'b0, len: 8'd40});
        @(posedge clk);
        #1 drive(0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check("b2b_second_start", 32'(outs(0)), 32'({1'b0, 1'b0, 3'd1}));
        wait_idle(0);

        repeat (4) @(negedge clk);
        check("dut0_all_frames_seen", 32'(exp_q0.size()), 32'd0);
        check("dut1_all_frames_seen", 32'(exp_q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_tx_frame.md
Name: serial_tx_frame

Overview:
Serial transmitter at the far end of the controller's PARALLEL_LOAD / Tx_DATA / Tx_DONE interface. It captures a parallel data word from memory and shifts it out on a single line as a UART-style frame: start bit, data LSB first, optional parity, one stop bit. It reports completion on Tx_DONE, which the controller polls to sequence its read flow. The block sits between the memory read data bus and the external serial pin.

Parameters:
DATA_WIDTH, 8, width of the parallel word and number of data bits per frame
BAUD_DIV, 4, CLK cycles per serial bit (minimum 1)
PARITY_EN, 0, 1 = insert a parity bit after the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (used only when PARITY_EN=1)

Ports:
CLK  input  1  system clock; all state changes on the rising edge
RESET  input  1  synchronous, active-high reset
DATA_IN  input  DATA_WIDTH  parallel word from memory
PARALLEL_LOAD  input  1  capture DATA_IN into the shift register
Tx_DATA  input  1  start transmission of the held word
TX_OUT  output  1  serial line; idle high, registered
Tx_DONE  output  1  1 = idle/finished, 0 = frame in progress; registered
DEBUG_STATE  output  3  current FSM state encoding

Behaviour:
- Clocking and reset: one clock, CLK. RESET is synchronous and active-high. While RESET=1 at a rising edge:
  - state <= IDLE; shift register <= 0; bit counter <= 0; baud counter <= 0
  - TX_OUT <= 1; Tx_DONE <= 1
- A RESET that arrives mid-frame aborts the frame. TX_OUT returns to 1 on the next edge; no partial stop bit is sent.
- States and encodings: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
- IDLE: TX_OUT=1, Tx_DONE=1.
  - PARALLEL_LOAD=1: shift register <= DATA_IN.
  - Tx_DATA=1: go to START. TX_OUT <= 0 and Tx_DONE <= 0 on that same edge.
  - PARALLEL_LOAD and Tx_DATA both high in one cycle: the word on DATA_IN in that cycle is the one transmitted (load-and-start).
  - Tx_DATA without a prior load: the shift register's current contents are sent.
- Start-to-Tx_DONE latency: Tx_DONE must read 0 in the cycle immediately after the start edge. The controller samples Tx_DONE in its following state and depends on this.
- Bit timing: each serial bit is held on TX_OUT for exactly BAUD_DIV cycles. The baud counter runs 0..BAUD_DIV-1; at BAUD_DIV-1 the block advances to the next bit and the counter wraps to 0.
- START: TX_OUT=0 for one bit time, then DATA.
- DATA: TX_OUT = shift register bit 0, LSB first. The register shifts right once per bit. After DATA_WIDTH bits (bit counter reaches DATA_WIDTH-1 with the baud counter at its end) go to PARITY if PARITY_EN=1, else STOP.
- PARITY: TX_OUT = XOR of the original data bits, XOR PARITY_ODD. The parity value is computed at load time and held for the whole frame.
- STOP: TX_OUT=1 for one bit time. On the final edge: state <= IDLE, Tx_DONE <= 1.
- Frame length: Tx_DONE stays 0 for exactly (2 + DATA_WIDTH + PARITY_EN) × BAUD_DIV cycles.
- While busy (any state other than IDLE):
  - PARALLEL_LOAD and Tx_DATA are ignored; the shift register is not disturbed.
  - DATA_IN may change freely without affecting the frame.
- Back-to-back frames: a Tx_DATA sampled in the first cycle Tx_DONE=1 starts a new frame on that edge. Minimum idle gap between frames is 1 cycle.
- TX_OUT and Tx_DONE are driven directly from flops; no combinational path from any input to either output.

Test Plan:
- RESET held 3 cycles, then released with all inputs 0 → TX_OUT=1, Tx_DONE=1, DEBUG_STATE=0 for 10 cycles.
- Defaults; DATA_IN=8'hA5 with PARALLEL_LOAD=1 and Tx_DATA=1 in the same cycle →
  - TX_OUT sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles
  - Tx_DONE=0 on the cycle after the start edge, for exactly 40 cycles, then 1
- PARITY_EN=1, PARITY_ODD=0, load 8'hA5 then start on the next cycle →
  - parity bit = 0, frame length 44 cycles
  - repeat with 8'h07 → parity bit = 1
- Load 8'h3C and start; mid-DATA pulse PARALLEL_LOAD with DATA_IN=8'hFF and pulse Tx_DATA → transmitted bits remain 0,0,1,1,1,1,0,0; no restart.
- RESET asserted during the 4th data bit → next edge TX_OUT=1, Tx_DONE=1, state IDLE; a new start afterwards sends a clean full frame.
- Two frames (8'h01 then 8'h80) with Tx_DATA issued on the first cycle Tx_DONE=1 → second start bit begins 1 cycle after Tx_DONE rises; both frames decode correctly.
